// File: rtl/pipe_ctrl_gen.sv
// Pipeline control generator: stall vector, exception flush sequencer, stall watchdog.
// Latency: stall_o is combinational from stallreq_i; flush_o/new_pc_o follow excp_i by one cycle.
// Backpressure: none; stall_o is the backpressure the block hands to the pipeline.
// Optional macro PIPE_CTRL_PERF_EN adds a saturating total stalled-cycle counter on stall_cnt_o.
module pipe_ctrl_gen #(
    parameter int STAGES      = 6,
    parameter int FLUSH_LEN   = 1,
    parameter int STALL_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic              excp_i,
    input  logic [31:0]       excp_pc_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              stall_timeout_o,
    output logic [31:0]       stall_cnt_o
);

    localparam logic [3:0]  FLEN = 4'(FLUSH_LEN);
    localparam logic [15:0] SLIM = 16'(STALL_LIMIT);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [31:0]   pc_q, pc_d;
    logic [15:0]   scnt_q, scnt_d;
    logic          timeout_q, timeout_d;
    logic [STAGES-1:0] stall_therm;
    logic          stall_any;

    // Thermometer fill downward from the highest requesting stage; flush and reset mask it.
    always_comb begin
        logic acc;
        acc         = 1'b0;
        stall_therm = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc            = acc | stallreq_i[k];
            stall_therm[k] = acc;
        end
        stall_o = (rst || (state_q == FLUSH)) ? '0 : stall_therm;
    end

    assign stall_any = |stall_o;

    // Flush sequencer next state: a new exception always restarts the window (last one wins).
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (excp_i) begin
                    state_d = FLUSH;
                    fcnt_d  = FLEN;
                    pc_d    = excp_pc_i;
                end
            end
            FLUSH: begin
                if (excp_i) begin
                    fcnt_d = FLEN;
                    pc_d   = excp_pc_i;
                end else if (fcnt_q == 4'd1) begin
                    state_d = IDLE;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // Watchdog next state: the run counter saturates, and the flag is sticky until reset.
    always_comb begin
        scnt_d    = scnt_q;
        timeout_d = timeout_q;
        if (!stall_any) begin
            scnt_d = 16'd0;
        end else begin
            if (scnt_q != SLIM) begin
                scnt_d = scnt_q + 16'd1;
            end
            if (scnt_q == SLIM) begin
                timeout_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fcnt_q    <= 4'd0;
            pc_q      <= 32'h0;
            scnt_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pc_q      <= pc_d;
            scnt_q    <= scnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign flush_o         = (state_q == FLUSH);
    assign new_pc_o        = pc_q;
    assign stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Total stalled cycles, saturating so a long run never wraps to a misleading small value.
    always_comb begin
        perf_d = perf_q;
        if (stall_any && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 32'h0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cnt_o = perf_q;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen: directed scenarios then random traffic against a reference model.
// Model tracks remaining flush cycles and stall run length as plain integers.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_pipe_ctrl_gen;

    localparam int STAGES      = 6;
    localparam int FLUSH_LEN   = 3;
    localparam int STALL_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stallreq_i;
    logic              excp_i;
    logic [31:0]       excp_pc_i;
    logic [STAGES-1:0] stall_o;
    logic              flush_o;
    logic [31:0]       new_pc_o;
    logic              stall_timeout_o;
    logic [31:0]       stall_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          m_rem;
    logic [31:0] m_pc;
    int          m_run;
    logic        m_to;
    logic [31:0] m_tot;

    pipe_ctrl_gen #(
        .STAGES     (STAGES),
        .FLUSH_LEN  (FLUSH_LEN),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_i     (stallreq_i),
        .excp_i         (excp_i),
        .excp_pc_i      (excp_pc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .stall_timeout_o(stall_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [STAGES-1:0] exp_stall(input logic r, input logic [STAGES-1:0] req);
        logic [STAGES-1:0] e;
        int h;
        e = '0;
        h = -1;
        if (r || (m_rem > 0)) return '0;
        for (int i = 0; i < STAGES; i++) if (req[i]) h = i;
        for (int i = 0; i < STAGES; i++) if (i <= h) e[i] = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] exp_perf();
`ifdef PIPE_CTRL_PERF_EN
        return m_tot;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_rem = 0;
        m_pc  = 32'h0;
        m_run = 0;
        m_to  = 1'b0;
        m_tot = 32'h0;
    endtask

    // One clock cycle: drive, check all outputs at negedge, advance model at posedge.
    task automatic step(input logic r, input logic [STAGES-1:0] req, input logic e,
                        input logic [31:0] pc);
        logic [STAGES-1:0] es;
        rst        = r;
        stallreq_i = req;
        excp_i     = e;
        excp_pc_i  = pc;
        @(negedge clk);
        es = exp_stall(r, req);
        chk("stall_o", 32'(stall_o), 32'(es));
        chk("flush_o", 32'(flush_o), 32'(m_rem > 0));
        chk("new_pc_o", new_pc_o, m_pc);
        chk("stall_timeout_o", 32'(stall_timeout_o), 32'(m_to));
        chk("stall_cnt_o", stall_cnt_o, exp_perf());
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (es != '0) begin
                if (m_run >= STALL_LIMIT) m_to = 1'b1;
                m_run++;
                if (m_tot != 32'hFFFF_FFFF) m_tot = m_tot + 32'd1;
            end else begin
                m_run = 0;
            end
            if (e) begin
                m_rem = FLUSH_LEN;
                m_pc  = pc;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
        #1;
    endtask

    initial begin
        logic [STAGES-1:0] req_tab [4];
        logic [STAGES-1:0] exp_tab [4];
        req_tab = '{6'b000001, 6'b000100, 6'b001000, 6'b100010};
        exp_tab = '{6'b000001, 6'b000111, 6'b001111, 6'b111111};

        rst = 1'b1; stallreq_i = '0; excp_i = 1'b0; excp_pc_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // reset state, including reset beating a same-cycle exception
        step(1'b1, 6'b111111, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 6'b000000, 1'b0, 32'h0);
        chk("rst_wins_flush", 32'(flush_o), 32'h0);

        // same-cycle thermometer fill
        rst = 1'b0; excp_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stallreq_i = req_tab[i];
            #1;
            chk("therm", 32'(stall_o), 32'(exp_tab[i]));
        end
        step(1'b0, 6'b000000, 1'b0, 32'h0);

        // single exception: flush window masks stalls
        step(1'b0, 6'b000000, 1'b1, 32'h0000_0100);
        chk("flush_start", 32'(flush_o), 32'h1);
        chk("flush_pc", new_pc_o, 32'h100);
        repeat (3) step(1'b0, 6'b001000, 1'b0, 32'h0);
        chk("flush_end", 32'(flush_o), 32'h0);
        chk("pc_hold", new_pc_o, 32'h100);
        step(1'b0, 6'b000000, 1'b0, 32'h0);

        // back-to-back exceptions: last wins and window restarts
        step(1'b0, 6'b000000, 1'b1, 32'h0000_00A0);
        step(1'b0, 6'b000000, 1'b1, 32'h0000_00B0);
        chk("b2b_pc", new_pc_o, 32'hB0);
        repeat (4) step(1'b0, 6'b000000, 1'b0, 32'h0);

        // short burst stays below the watchdog, long run trips it
        repeat (3) step(1'b0, 6'b000001, 1'b0, 32'h0);
        step(1'b0, 6'b000000, 1'b0, 32'h0);
        chk("burst_no_to", 32'(stall_timeout_o), 32'h0);
        repeat (4) step(1'b0, 6'b000001, 1'b0, 32'h0);
        chk("to_not_yet", 32'(stall_timeout_o), 32'h0);
        repeat (6) step(1'b0, 6'b000001, 1'b0, 32'h0);
        repeat (3) step(1'b0, 6'b000000, 1'b0, 32'h0);
        chk("to_sticky", 32'(stall_timeout_o), 32'h1);

        // reset in the middle of a flush
        step(1'b0, 6'b000000, 1'b1, 32'h0000_0CC0);
        step(1'b1, 6'b000000, 1'b0, 32'h0);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_pc", new_pc_o, 32'h0);
        chk("rst_cnt", stall_cnt_o, 32'h0);
        chk("rst_to", 32'(stall_timeout_o), 32'h0);

        // seven stalled cycles for the performance counter
        repeat (7) step(1'b0, 6'b000010, 1'b0, 32'h0);
        step(1'b0, 6'b000000, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf7", stall_cnt_o, 32'd7);
`else
        chk("perf7", stall_cnt_o, 32'd0);
`endif

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic              r, e;
            logic [STAGES-1:0] q;
            r = ($urandom_range(39) == 0);
            e = ($urandom_range(5) == 0);
            q = ($urandom_range(2) == 0) ? '0 : STAGES'($urandom);
            step(r, q, e, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "bench timeout");
    end

endmodule
